// File: rtl/edge_counter_if.sv
// Bundle between the RX FSM and the oversampling edge counter.
// The FSM drives enable/prescale; the counter returns its bit and edge indices.
interface edge_counter_if #(
  parameter int PWIDTH = 6
);
  logic              enable;
  logic [PWIDTH-1:0] prescale;
  logic [PWIDTH-2:0] bit_counter;
  logic [PWIDTH-1:0] edge_counter;

  modport master (
    output enable,
    output prescale,
    input  bit_counter,
    input  edge_counter
  );

  modport slave (
    input  enable,
    input  prescale,
    output bit_counter,
    output edge_counter
  );
endinterface

// File: rtl/edge_counter.sv
// Oversampling tick counter for the UART receiver: counts sampling edges
// within one bit period of `prescale` edges and counts completed bit periods.
module edge_counter #(
  parameter int PWIDTH = 6
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  edge_counter_if.slave  bus
);

  logic [PWIDTH-1:0] edgeCnt_q, edgeCnt_d;
  logic [PWIDTH-2:0] bitCnt_q, bitCnt_d;
  logic              terminalEdge;

  // edge+1 >= prescale at PWIDTH+1 bits: same as edge >= prescale-1, but a
  // prescale of 0 or 1 makes every enabled cycle terminal instead of underflowing.
  assign terminalEdge = ({1'b0, edgeCnt_q} + {{PWIDTH{1'b0}}, 1'b1}) >= {1'b0, bus.prescale};

  always_comb begin
    edgeCnt_d = edgeCnt_q;
    bitCnt_d  = bitCnt_q;
    if (!bus.enable) begin
      edgeCnt_d = '0;
      bitCnt_d  = '0;
    end else if (terminalEdge) begin
      edgeCnt_d = '0;
      bitCnt_d  = bitCnt_q + 1'b1;
    end else begin
      edgeCnt_d = edgeCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      edgeCnt_q <= '0;
      bitCnt_q  <= '0;
    end else begin
      edgeCnt_q <= edgeCnt_d;
      bitCnt_q  <= bitCnt_d;
    end
  end

  assign bus.edge_counter = edgeCnt_q;
  assign bus.bit_counter  = bitCnt_q;

endmodule

// File: tb/tb_edge_counter.sv
// Scoreboard bench for edge_counter: a driver pushes expected counter values
// from an integer reference model, a monitor pops and compares each cycle.
module tb_edge_counter;

  localparam int PWIDTH  = 6;
  localparam int BITMOD  = 1 << (PWIDTH - 1);

  typedef struct {
    int edgeVal;
    int bitVal;
  } expT;

  logic clk;
  logic rst_ni;

  edge_counter_if #(.PWIDTH(PWIDTH)) bus ();

  edge_counter #(.PWIDTH(PWIDTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int  checks   = 0;
  int  failures = 0;
  int  maxEdge  = 0;
  int  cycleNo  = 0;
  expT expQ[$];

  // Reference model state: edge index in the bit and bit index in the frame.
  int modelEdge = 0;
  int modelBit  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a bit lasts `ps` edges (at least one); bits count mod 2^(PWIDTH-1).
  task automatic modelStep(input bit en, input int ps, input bit rstn);
    if (!rstn || !en) begin
      modelEdge = 0;
      modelBit  = 0;
    end else if (modelEdge + 1 >= ps) begin
      modelEdge = 0;
      modelBit  = (modelBit + 1) % BITMOD;
    end else begin
      modelEdge = modelEdge + 1;
    end
  endtask

  task automatic applyStimulus(input bit en, input int ps, input bit rstn);
    expT e;
    @(negedge clk);
    rst_ni       = rstn;
    bus.enable   = en;
    bus.prescale = ps[PWIDTH-1:0];
    modelStep(en, ps, rstn);
    e.edgeVal = modelEdge;
    e.bitVal  = modelBit;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int expEdge, input int expBit);
    checks++;
    if (int'(bus.edge_counter) != expEdge || int'(bus.bit_counter) != expBit) begin
      failures++;
      $display("[TB] FAIL %s: edge_counter=%0d (want %0d) bit_counter=%0d (want %0d)",
               name, bus.edge_counter, expEdge, bus.bit_counter, expBit);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Monitor: every clock the counters present a new value; compare it with the queue head.
  always @(posedge clk) begin
    expT e;
    #1;
    cycleNo++;
    if (int'(bus.edge_counter) > maxEdge) maxEdge = int'(bus.edge_counter);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (int'(bus.edge_counter) != e.edgeVal || int'(bus.bit_counter) != e.bitVal) begin
        failures++;
        $display("[TB] FAIL scoreboard cycle %0d: edge_counter=%0d (want %0d) bit_counter=%0d (want %0d)",
                 cycleNo, bus.edge_counter, e.edgeVal, bus.bit_counter, e.bitVal);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ps;
    bit en;
    bit rstn;
    int waitCycles;

    rst_ni       = 1'b0;
    bus.enable   = 1'b1;
    bus.prescale = 6'd8;
    #2;
    checkOutput("reset_initial", 0, 0);

    // Reset held with enable high and clock running.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8, 1'b0);
    checkOutput("reset_hold", 0, 0);

    // Release reset and raise enable together, 25 edges at prescale 8.
    for (int i = 0; i < 25; i++) applyStimulus(1'b1, 8, 1'b1);
    checkOutput("basic_count_25", 1, 3);

    // Restart frame, count to edge 4 / bit 1, drop enable for one cycle.
    applyStimulus(1'b0, 8, 1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 8, 1'b1);
    checkOutput("before_enable_drop", 4, 1);
    applyStimulus(1'b0, 8, 1'b1);
    checkOutput("enable_drop", 0, 0);
    applyStimulus(1'b1, 8, 1'b1);
    checkOutput("re_enable", 1, 0);

    // Count to edge 5 / bit 2, then assert reset between clock edges.
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8, 1'b1);
    checkOutput("before_async_reset", 5, 2);
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("async_reset_mid_bit", 0, 0);
    modelStep(1'b1, 8, 1'b0);
    applyStimulus(1'b1, 8, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8, 1'b1);
    checkOutput("restart_after_reset", 3, 0);

    // Prescale 16 and 32: two full bit periods each.
    applyStimulus(1'b0, 16, 1'b1);
    maxEdge = 0;
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 16, 1'b1);
    checkOutput("prescale16_two_bits", 0, 2);
    checkValue("prescale16_max_edge", maxEdge, 15);

    applyStimulus(1'b0, 32, 1'b1);
    maxEdge = 0;
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 32, 1'b1);
    checkOutput("prescale32_two_bits", 0, 2);
    checkValue("prescale32_max_edge", maxEdge, 31);

    // Prescale 1 and 0: bit counter steps every cycle and wraps.
    applyStimulus(1'b0, 1, 1'b1);
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1, 1'b1);
    checkOutput("prescale1_wrap_to_0", 0, 0);
    applyStimulus(1'b1, 1, 1'b1);
    checkOutput("prescale1_after_33", 0, 1);

    applyStimulus(1'b0, 0, 1'b1);
    maxEdge = 0;
    for (int i = 0; i < 33; i++) applyStimulus(1'b1, 0, 1'b1);
    checkOutput("prescale0_after_33", 0, 1);
    checkValue("prescale0_max_edge", maxEdge, 0);

    // Prescale shrink mid-bit.
    applyStimulus(1'b0, 16, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 16, 1'b1);
    checkOutput("shrink_before", 10, 0);
    applyStimulus(1'b1, 8, 1'b1);
    checkOutput("shrink_after", 0, 1);

    // Randomized frames: mostly-stable prescale, occasional enable drops and resets.
    ps = 8;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) ps = int'($urandom_range(0, (1 << PWIDTH) - 1));
      else if ($urandom_range(0, 19) == 0) ps = int'($urandom_range(0, 6));
      en   = ($urandom_range(0, 15) != 0);
      rstn = ($urandom_range(0, 49) != 0);
      applyStimulus(en, ps, rstn);
    end

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    checkValue("scoreboard_drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
